// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 7-segment scan scheduler.
//   SEG_OFF_N  all segments dark in active-low form
//   HEX_SEG    hex digit -> {g,f,e,d,c,b,a} positive-logic segment table
//   ST_*       scan FSM state encoding
package seg7_pkg;
    localparam logic [6:0] SEG_OFF_N = 7'h7F;
    // Index 15 (F) is the leftmost entry, index 0 the rightmost.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;
endpackage

// File: rtl/seg7_scan_scheduler_if.sv
// seg7_scan_scheduler_if: valid/ready load channel for new display values.
//   load_valid  master -> slave  new value offered
//   load_data   master -> slave  hex nibbles, nibble i -> digit i
//   load_ready  slave -> master  scheduler can accept this cycle
interface seg7_scan_scheduler_if #(
    parameter int NUM_DIGITS = 2
);
    logic                    load_valid;
    logic [4*NUM_DIGITS-1:0] load_data;
    logic                    load_ready;
    modport master (output load_valid, load_data, input load_ready);
    modport slave  (input load_valid, load_data, output load_ready);
endinterface

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: combinational hex nibble to positive-logic segment decode.
//   hex  in   4  digit value 0..F
//   seg  out  7  {g,f,e,d,c,b,a}, 1 = segment lit
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    assign seg = HEX_SEG[hex];
endmodule

// File: rtl/seg7_scan_scheduler.sv
// seg7_scan_scheduler: time-multiplexed digit scan with blanking guards, PWM and tear-free loads.
//   clk          in   1           system clock
//   rst_n        in   1           asynchronous active-low reset
//   enable       in   1           1 = scan, 0 = dark and counters held
//   brightness   in   4           PWM level, 0 = dark
//   load         slave            valid/ready channel carrying new display nibbles
//   seg_n        out  7           active-low segments {g,f,e,d,c,b,a}
//   digit_idx    out  DIW         selected digit
//   frame_start  out  1           one-cycle pulse at start of the digit-0 slot
module seg7_scan_scheduler
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 2,
    parameter int TICK_DIV     = 64,
    parameter int BLANK_CYCLES = 4,
    localparam int DIW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [3:0]           brightness,
    seg7_scan_scheduler_if.slave load,
    output logic [6:0]           seg_n,
    output logic [DIW-1:0]       digit_idx,
    output logic                 frame_start
);
    localparam int SW = $clog2(TICK_DIV);
    localparam logic [SW-1:0]  BLANK_LAST = SW'(BLANK_CYCLES - 1);
    localparam logic [SW-1:0]  SLOT_LAST  = SW'(TICK_DIV - 1);
    localparam logic [DIW-1:0] DIG_LAST   = DIW'(NUM_DIGITS - 1);

    logic [1:0]              state, state_nx;
    logic [SW-1:0]           slot_cnt, slot_nx;
    logic [DIW-1:0]          dig, dig_nx;
    logic [4*NUM_DIGITS-1:0] active, pending;
    logic                    pending_full;
    logic [3:0]              pwm_phase;
    logic [6:0]              seg;
    logic                    blank_end, slot_end, f0, lit, commit, accept;

    hex_to_seg7 u_dec (.hex(active[{dig, 2'b00} +: 4]), .seg(seg));

    assign blank_end = state == ST_BLANK && slot_cnt == BLANK_LAST;
    assign slot_end  = state == ST_SHOW && slot_cnt == SLOT_LAST;
    // First cycle of the digit-0 blanking guard: the frame boundary.
    assign f0        = state == ST_BLANK && slot_cnt == '0 && dig == '0;
    // Only the low nibble of the SHOW-relative count drives the 16-step PWM.
    assign pwm_phase = slot_cnt[3:0] - 4'(BLANK_CYCLES);
    assign lit       = state == ST_SHOW && pwm_phase < brightness;
    // Swapping buffers while digit 0 is blanked keeps every digit of a frame on one value.
    assign commit    = pending_full && (f0 || state == ST_IDLE);
    assign accept    = load.load_valid && !pending_full;
    assign load.load_ready = !pending_full;

    always_comb begin
        state_nx = !enable ? ST_IDLE :
                   state == ST_IDLE ? ST_BLANK :
                   blank_end ? ST_SHOW :
                   slot_end ? ST_BLANK : state;
        slot_nx  = (!enable || state == ST_IDLE || slot_end) ? '0 : slot_cnt + SW'(1);
        dig_nx   = (!enable || state == ST_IDLE) ? '0 :
                   slot_end ? (dig == DIG_LAST ? '0 : dig + DIW'(1)) : dig;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            slot_cnt     <= '0;
            dig          <= '0;
            active       <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            seg_n        <= SEG_OFF_N;
            digit_idx    <= '0;
            frame_start  <= 1'b0;
        end else begin
            state        <= state_nx;
            slot_cnt     <= slot_nx;
            dig          <= dig_nx;
            seg_n        <= (enable && lit) ? ~seg : SEG_OFF_N;
            digit_idx    <= enable ? dig : '0;
            frame_start  <= enable && f0;
            if (commit) active <= pending;
            if (accept) pending <= load.load_data;
            pending_full <= commit ? 1'b0 : accept ? 1'b1 : pending_full;
        end
    end
endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// tb_seg7_scan_scheduler: directed self-checking bench for seg7_scan_scheduler.
//   dut_a: NUM_DIGITS=2, TICK_DIV=16, BLANK_CYCLES=2 (frame = 32 cycles)
//   dut_b: NUM_DIGITS=2, TICK_DIV=64, BLANK_CYCLES=4 (PWM duty check)
module tb_seg7_scan_scheduler;
    localparam logic [6:0] HEX_TAB [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_a, en_b;
    logic [3:0] br_a, br_b;
    logic [6:0] seg_a, seg_b;
    logic       dig_a, dig_b;
    logic       fs_a, fs_b;

    int         n_checks = 0;
    int         n_fail = 0;
    // Reference model of the load path of dut_a.
    logic [7:0] act_m, pend_m;
    logic       pf, want;
    int         lit_all, lit_16;

    seg7_scan_scheduler_if #(.NUM_DIGITS(2)) if_a ();
    seg7_scan_scheduler_if #(.NUM_DIGITS(2)) if_b ();

    seg7_scan_scheduler #(.NUM_DIGITS(2), .TICK_DIV(16), .BLANK_CYCLES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .brightness(br_a), .load(if_a),
        .seg_n(seg_a), .digit_idx(dig_a), .frame_start(fs_a)
    );

    seg7_scan_scheduler #(.NUM_DIGITS(2), .TICK_DIV(64), .BLANK_CYCLES(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .brightness(br_b), .load(if_b),
        .seg_n(seg_b), .digit_idx(dig_b), .frame_start(fs_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        return ~HEX_TAB[n];
    endfunction

    task automatic wait_fs(input bit on_b);
        int n = 0;
        while ((on_b ? fs_b : fs_a) !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check(on_b ? "wait_fs_b" : "wait_fs_a", {31'd0, on_b ? fs_b : fs_a}, 1);
    endtask

    // Checks one 32-cycle frame of dut_a starting at its frame_start cycle,
    // optionally offering loads at cycles a_at / b_at (held until accepted).
    task automatic check_frame(input logic [3:0] bright, input int a_at, input logic [7:0] a_val,
                               input int b_at, input logic [7:0] b_val);
        int         d, ph;
        logic [6:0] es;
        logic       xfer;
        for (int i = 0; i < 32; i++) begin
            d  = i / 16;
            ph = i % 16;
            if (i == a_at) begin want = 1'b1; if_a.load_data = a_val; end
            if (i == b_at) begin want = 1'b1; if_a.load_data = b_val; end
            if_a.load_valid = want;
            br_a = bright;
            es = (ph >= 2 && (ph - 2) < int'(bright)) ? seg_of(act_m[d*4 +: 4]) : 7'h7F;
            check($sformatf("seg[%0d]", i), {25'd0, seg_a}, {25'd0, es});
            check($sformatf("dig[%0d]", i), {31'd0, dig_a}, d);
            check($sformatf("fs[%0d]", i), {31'd0, fs_a}, {31'd0, i == 0});
            check($sformatf("rdy[%0d]", i), {31'd0, if_a.load_ready}, {31'd0, !pf});
            xfer = want && !pf;
            if (xfer) begin
                pf = 1'b1;
                want = 1'b0;
                pend_m = if_a.load_data;
            end else if (pf && i == 31) begin
                pf = 1'b0;
                act_m = pend_m;
            end
            tick();
        end
        if_a.load_valid = want;
    endtask

    initial begin
        rst_n = 1'b0;
        en_a = 1'b0; br_a = 4'd0; en_b = 1'b0; br_b = 4'd0;
        if_a.load_valid = 1'b0; if_a.load_data = 8'h00;
        if_b.load_valid = 1'b0; if_b.load_data = 8'h00;
        act_m = 8'h00; pend_m = 8'h00; pf = 1'b0; want = 1'b0;
        repeat (3) tick();
        check("rst_seg", {25'd0, seg_a}, 32'h7F);
        check("rst_dig", {31'd0, dig_a}, 0);
        check("rst_fs", {31'd0, fs_a}, 0);
        check("rst_rdy", {31'd0, if_a.load_ready}, 1);
        rst_n = 1'b1;
        tick();

        // Load "21" while idle: accepted, then committed on the following cycle.
        if_a.load_valid = 1'b1; if_a.load_data = 8'h21;
        check("idle_rdy0", {31'd0, if_a.load_ready}, 1);
        tick();
        if_a.load_valid = 1'b0;
        check("idle_rdy1", {31'd0, if_a.load_ready}, 0);
        tick();
        check("idle_rdy2", {31'd0, if_a.load_ready}, 1);
        act_m = 8'h21;
        en_a = 1'b1; br_a = 4'd15;
        tick();
        check("en_fs0", {31'd0, fs_a}, 0);
        tick();
        check("en_fs1", {31'd0, fs_a}, 1);
        check_frame(4'd15, -1, 8'h00, -1, 8'h00);
        check_frame(4'd15, -1, 8'h00, -1, 8'h00);

        // Brightness 0 keeps the display dark.
        check_frame(4'd0, -1, 8'h00, -1, 8'h00);

        // Mid-frame load of "43": shown only from the next frame.
        check_frame(4'd15, 5, 8'h43, -1, 8'h00);
        check_frame(4'd15, -1, 8'h00, -1, 8'h00);

        // Enable drop mid-slot with a pending load of "65".
        for (int i = 0; i < 20; i++) begin
            if_a.load_valid = (i == 3);
            if_a.load_data  = 8'h65;
            if (i == 4) check("drop_rdy_full", {31'd0, if_a.load_ready}, 0);
            tick();
        end
        check("drop_pre_seg", {25'd0, seg_a}, {25'd0, seg_of(4'h4)});
        en_a = 1'b0;
        tick();
        check("drop_seg", {25'd0, seg_a}, 32'h7F);
        check("drop_dig", {31'd0, dig_a}, 0);
        check("drop_rdy0", {31'd0, if_a.load_ready}, 0);
        tick();
        check("drop_rdy1", {31'd0, if_a.load_ready}, 1);
        check("drop_seg1", {25'd0, seg_a}, 32'h7F);
        act_m = 8'h65; pf = 1'b0;
        repeat (3) tick();
        check("idle_fs", {31'd0, fs_a}, 0);
        en_a = 1'b1;
        tick();
        check("reen_fs0", {31'd0, fs_a}, 0);
        tick();
        check("reen_fs1", {31'd0, fs_a}, 1);
        check_frame(4'd15, -1, 8'h00, -1, 8'h00);

        // Held load_valid while pending is full; walks all 16 nibble values.
        check_frame(4'd15, 3, 8'h10, 6, 8'h32);
        for (int k = 1; k < 7; k++)
            check_frame(4'd15, -1, 8'h00, 6, {4'(2*k + 3), 4'(2*k + 2)});
        check_frame(4'd15, -1, 8'h00, -1, 8'h00);
        check_frame(4'd15, -1, 8'h00, -1, 8'h00);

        // PWM duty on the 64-cycle slot instance at brightness 8.
        if_b.load_valid = 1'b1; if_b.load_data = 8'h88;
        tick();
        if_b.load_valid = 1'b0;
        repeat (2) tick();
        en_b = 1'b1; br_b = 4'd8;
        wait_fs(1'b1);
        lit_all = 0; lit_16 = 0;
        for (int i = 0; i < 64; i++) begin
            if (seg_b !== 7'h7F) begin
                lit_all++;
                if (i >= 4 && i < 20) lit_16++;
            end
            if (i == 4) check("b_seg8", {25'd0, seg_b}, {25'd0, seg_of(4'h8)});
            tick();
        end
        check("b_lit_slot", lit_all, 32);
        check("b_lit_16", lit_16, 8);
        check("b_dig1", {31'd0, dig_b}, 1);

        // Asynchronous reset mid-SHOW with a pending load.
        wait_fs(1'b0);
        repeat (3) tick();
        if_a.load_valid = 1'b1; if_a.load_data = 8'h99;
        tick();
        if_a.load_valid = 1'b0;
        check("arst_rdy_full", {31'd0, if_a.load_ready}, 0);
        tick();
        check("arst_pre_seg", {25'd0, seg_a}, {25'd0, seg_of(4'hE)});
        rst_n = 1'b0;
        #1;
        check("arst_seg", {25'd0, seg_a}, 32'h7F);
        check("arst_dig", {31'd0, dig_a}, 0);
        check("arst_fs", {31'd0, fs_a}, 0);
        check("arst_rdy", {31'd0, if_a.load_ready}, 1);
        check("arst_seg_b", {25'd0, seg_b}, 32'h7F);
        tick();
        rst_n = 1'b1;
        act_m = 8'h00; pf = 1'b0; want = 1'b0;
        tick();
        check("post_rst_fs0", {31'd0, fs_a}, 0);
        tick();
        check("post_rst_fs1", {31'd0, fs_a}, 1);
        check_frame(4'd15, -1, 8'h00, -1, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
